// File: rtl/nv_nvdla_rubik_rd_cdt_ctrl.sv
// Rubik read-command splitter: breaks a command into 32B/64B DMA read requests,
// throttled by a credit counter that mirrors free entries in the downstream latency FIFO.
module nv_nvdla_rubik_rd_cdt_ctrl #(
  parameter int unsigned LAT_FIFO_DEPTH = 64,
  parameter int unsigned CDT_W          = 7
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [63:0]      cmd_addr,
  input  logic [14:0]      cmd_len,
  output logic             rd_req_vld,
  input  logic             rd_req_rdy,
  output logic [78:0]      rd_req_pd,
  input  logic             rd_cdt_lat_fifo_pop,
  output logic             cmd_done,
  output logic [CDT_W-1:0] cdt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [CDT_W-1:0] CDT_MAX = CDT_W'(LAT_FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [63:0]      cur_addr_q, cur_addr_d;
  logic [15:0]      remain_q, remain_d;
  logic [CDT_W-1:0] cdt_cnt_q, cdt_cnt_d;
  logic             cmd_done_q, cmd_done_d;

  logic             req_64b;
  logic             req_fire;
  logic [15:0]      remain_nxt;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[4:0];

  // A 64B request must not straddle a 64B boundary and must not overrun the command.
  assign req_64b    = !(cur_addr_q[5] || (remain_q == 16'd1));
  assign remain_nxt = remain_q - (req_64b ? 16'd2 : 16'd1);

  assign cmd_rdy    = (state_q == IDLE);
  assign rd_req_vld = (state_q == REQ) && (cdt_cnt_q != '0) && !nvdla_core_rst;
  assign rd_req_pd  = {14'd0, req_64b, cur_addr_q};
  assign req_fire   = rd_req_vld && rd_req_rdy;
  assign cmd_done   = cmd_done_q;
  assign cdt_cnt    = cdt_cnt_q;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    cmd_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          cur_addr_d = {cmd_addr[63:5], 5'b0};
          remain_d   = {1'b0, cmd_len} + 16'd1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (req_fire) begin
          cur_addr_d = cur_addr_q + (req_64b ? 64'd64 : 64'd32);
          remain_d   = remain_nxt;
          if (remain_nxt == '0) begin
            state_d    = IDLE;
            cmd_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits are independent of the FSM; a pop and a request in the same cycle cancel.
  always_comb begin
    cdt_cnt_d = cdt_cnt_q;
    if (rd_cdt_lat_fifo_pop && !req_fire) begin
      cdt_cnt_d = (cdt_cnt_q == CDT_MAX) ? cdt_cnt_q : cdt_cnt_q + 1'b1;
    end else if (req_fire && !rd_cdt_lat_fifo_pop) begin
      cdt_cnt_d = cdt_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      cdt_cnt_q  <= CDT_MAX;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      cdt_cnt_q  <= cdt_cnt_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  cdt_overflow_chk: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(rd_cdt_lat_fifo_pop && !req_fire && (cdt_cnt_q == CDT_MAX)));

  cdt_underflow_chk: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(req_fire && (cdt_cnt_q == '0)));

endmodule

// File: tb/tb_nv_nvdla_rubik_rd_cdt_ctrl.sv
// Directed bench: expected read requests are queued when a command is driven and
// popped/compared by a monitor on every request handshake.
module tb_nv_nvdla_rubik_rd_cdt_ctrl;

  logic        clk;
  logic        rst;

  logic        a_cmd_vld, a_cmd_rdy, a_vld, a_rdy, a_pop, a_done;
  logic [63:0] a_cmd_addr;
  logic [14:0] a_cmd_len;
  logic [78:0] a_pd;
  logic [6:0]  a_cdt;

  logic        b_cmd_vld, b_cmd_rdy, b_vld, b_rdy, b_pop, b_done;
  logic [63:0] b_cmd_addr;
  logic [14:0] b_cmd_len;
  logic [78:0] b_pd;
  logic [2:0]  b_cdt;

  logic [78:0] qa[$];
  logic [78:0] qb[$];

  int tests;
  int fails;

  nv_nvdla_rubik_rd_cdt_ctrl #(.LAT_FIFO_DEPTH(64), .CDT_W(7)) dut_a (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .cmd_vld             (a_cmd_vld),
    .cmd_rdy             (a_cmd_rdy),
    .cmd_addr            (a_cmd_addr),
    .cmd_len             (a_cmd_len),
    .rd_req_vld          (a_vld),
    .rd_req_rdy          (a_rdy),
    .rd_req_pd           (a_pd),
    .rd_cdt_lat_fifo_pop (a_pop),
    .cmd_done            (a_done),
    .cdt_cnt             (a_cdt)
  );

  nv_nvdla_rubik_rd_cdt_ctrl #(.LAT_FIFO_DEPTH(4), .CDT_W(3)) dut_b (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .cmd_vld             (b_cmd_vld),
    .cmd_rdy             (b_cmd_rdy),
    .cmd_addr            (b_cmd_addr),
    .cmd_len             (b_cmd_len),
    .rd_req_vld          (b_vld),
    .rd_req_rdy          (b_rdy),
    .rd_req_pd           (b_pd),
    .rd_cdt_lat_fifo_pop (b_pop),
    .cmd_done            (b_done),
    .cdt_cnt             (b_cdt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [78:0] mk(input logic [63:0] addr, input logic sz);
    return {14'd0, sz, addr};
  endfunction

  task automatic check(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (a_vld && a_rdy) begin
      tests++;
      assert (qa.size() != 0) else begin
        fails++;
        $error("FAIL a_unexpected_req: observed pd %0h expected none", a_pd);
      end
      if (qa.size() != 0) check("a_req_pd", a_pd, qa.pop_front());
    end
    if (b_vld && b_rdy) begin
      tests++;
      assert (qb.size() != 0) else begin
        fails++;
        $error("FAIL b_unexpected_req: observed pd %0h expected none", b_pd);
      end
      if (qb.size() != 0) check("b_req_pd", b_pd, qb.pop_front());
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a_cmd_vld = 1'b0; a_cmd_addr = '0; a_cmd_len = '0; a_rdy = 1'b1; a_pop = 1'b0;
    b_cmd_vld = 1'b0; b_cmd_addr = '0; b_cmd_len = '0; b_rdy = 1'b1; b_pop = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_cmd_rdy", a_cmd_rdy, 1);
    check("rst_cdt", a_cdt, 64);
    check("rst_vld", a_vld, 0);
    check("rst_done", a_done, 0);
    check("rst_cdt_b", b_cdt, 4);

    // Aligned 4-atom command: two 64B requests.
    qa.push_back(mk(64'h1000, 1'b1));
    qa.push_back(mk(64'h1040, 1'b1));
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h1000; a_cmd_len = 15'd3;
    step();
    a_cmd_vld = 1'b0;
    check("t1_busy", a_cmd_rdy, 0);
    check("t1_vld", a_vld, 1);
    step();
    check("t1_cdt_mid", a_cdt, 63);
    step();
    check("t1_done", a_done, 1);
    check("t1_cdt", a_cdt, 62);
    check("t1_cmd_rdy", a_cmd_rdy, 1);
    check("t1_queue", qa.size(), 0);
    step();
    check("t1_done_pulse", a_done, 0);

    // Misaligned start (low address bits set and must be dropped): 32B, 64B, 32B.
    qa.push_back(mk(64'h1020, 1'b0));
    qa.push_back(mk(64'h1040, 1'b1));
    qa.push_back(mk(64'h1080, 1'b0));
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h103F; a_cmd_len = 15'd3;
    step();
    a_cmd_vld = 1'b0;
    step();
    step();
    step();
    check("t2_done", a_done, 1);
    check("t2_cdt", a_cdt, 59);
    check("t2_queue", qa.size(), 0);

    // Stall with a pop in the middle.
    qa.push_back(mk(64'h2000, 1'b1));
    a_rdy = 1'b0;
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h2000; a_cmd_len = 15'd1;
    step();
    a_cmd_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_vld", a_vld, 1);
      check("t3_stall_pd", a_pd, mk(64'h2000, 1'b1));
      check("t3_stall_cdt", a_cdt, (i < 3) ? 59 : 60);
      a_pop = (i == 2);
      step();
    end
    a_pop = 1'b0;
    a_rdy = 1'b1;
    step();
    check("t3_cdt_after", a_cdt, 59);
    check("t3_done", a_done, 1);

    // Pop coincident with handshake, then back-to-back command in the done cycle.
    qa.push_back(mk(64'h3000, 1'b1));
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h3000; a_cmd_len = 15'd1;
    step();
    a_cmd_vld = 1'b0;
    a_pop = 1'b1;
    step();
    a_pop = 1'b0;
    check("t4_cdt_same", a_cdt, 59);
    check("t4_done", a_done, 1);
    check("t4_rdy_in_done", a_cmd_rdy, 1);
    qa.push_back(mk(64'h4000, 1'b0));
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h4000; a_cmd_len = 15'd0;
    step();
    a_cmd_vld = 1'b0;
    check("t4_b2b_accepted", a_cmd_rdy, 0);
    check("t4_b2b_pd", a_pd, mk(64'h4000, 1'b0));
    step();
    check("t4_b2b_done", a_done, 1);
    check("t4_b2b_cdt", a_cdt, 58);
    a_pop = 1'b1;
    repeat (6) step();
    a_pop = 1'b0;
    check("idle_pop_refill", a_cdt, 64);

    // Reset mid-command after two of eight requests.
    qa.push_back(mk(64'h5000, 1'b1));
    qa.push_back(mk(64'h5040, 1'b1));
    a_cmd_vld = 1'b1; a_cmd_addr = 64'h5000; a_cmd_len = 15'd15;
    step();
    a_cmd_vld = 1'b0;
    step();
    step();
    check("t5_cdt_pre", a_cdt, 62);
    rst = 1'b1;
    a_pop = 1'b1;
    step();
    rst = 1'b0;
    a_pop = 1'b0;
    check("t5_cmd_rdy", a_cmd_rdy, 1);
    check("t5_cdt", a_cdt, 64);
    check("t5_no_done", a_done, 0);
    check("t5_vld", a_vld, 0);
    check("t5_queue", qa.size(), 0);
    step();
    check("t5_no_done_late", a_done, 0);
    check("t5_cdt_late", a_cdt, 64);

    // Depth-4 instance: credit exhaustion and single-credit release.
    qb.push_back(mk(64'h000, 1'b1));
    qb.push_back(mk(64'h040, 1'b1));
    qb.push_back(mk(64'h080, 1'b1));
    qb.push_back(mk(64'h0C0, 1'b1));
    b_cmd_vld = 1'b1; b_cmd_addr = 64'h0; b_cmd_len = 15'd15;
    step();
    b_cmd_vld = 1'b0;
    repeat (4) step();
    check("t6_vld_starved", b_vld, 0);
    check("t6_cdt_zero", b_cdt, 0);
    check("t6_pd_held", b_pd, mk(64'h100, 1'b1));
    check("t6_queue", qb.size(), 0);
    step();
    check("t6_vld_starved2", b_vld, 0);
    check("t6_pd_held2", b_pd, mk(64'h100, 1'b1));
    qb.push_back(mk(64'h100, 1'b1));
    b_pop = 1'b1;
    step();
    b_pop = 1'b0;
    check("t6_cdt_one", b_cdt, 1);
    check("t6_vld_one", b_vld, 1);
    step();
    check("t6_cdt_zero2", b_cdt, 0);
    check("t6_vld_zero2", b_vld, 0);
    check("t6_pd_next", b_pd, mk(64'h140, 1'b1));
    check("t6_queue2", qb.size(), 0);
    step();
    check("t6_vld_stays", b_vld, 0);
    check("t6_busy", b_cmd_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
